// File: rtl/fadd_align_cal_if.sv
// Operand/result bundle between the fp16 adder front end and its neighbours.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
interface fadd_align_cal_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [1:0]  rm_i;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] cal_frac;
    logic [4:0]  temp_exp;
    logic        sign;
    logic        is_nan;
    logic        is_inf;
    logic [9:0]  inf_nan_frac;
    logic [1:0]  rm;

    // Producer of operands / consumer of results.
    modport master (
        output in_valid, a, b, sub, rm_i, out_ready,
        input  in_ready, out_valid, cal_frac, temp_exp, sign, is_nan, is_inf,
               inf_nan_frac, rm
    );

    // The alignment/add stage itself.
    modport slave (
        input  in_valid, a, b, sub, rm_i, out_ready,
        output in_ready, out_valid, cal_frac, temp_exp, sign, is_nan, is_inf,
               inf_nan_frac, rm
    );
endinterface

// File: rtl/fadd_align_cal.sv
// fp16 adder front end: unpack/swap, align smaller operand with G/R/S, effective add/sub.
// Latency: 2 cycles from accepted operands to out_valid; throughput 1 per cycle.
// Backpressure: elastic 2-stage pipe, in_ready = s1 empty or s2 able to advance; outputs hold while stalled.
module fadd_align_cal (
    input  logic            clk,
    input  logic            rst,
    fadd_align_cal_if.slave io
);

    logic s1_valid;
    logic out_valid_q;
    logic s1_load;
    logic s2_load;

    assign s2_load     = ~out_valid_q | io.out_ready;
    assign s1_load     = ~s1_valid | s2_load;
    assign io.in_ready = s1_load;

    // ---------------- stage 1: unpack, swap, shift amount, special detect
    logic       eb_sign;
    logic       a_large;
    logic       sign_l;
    logic       sign_s;
    logic [4:0] exp_l;
    logic [4:0] exp_s;
    logic [9:0] frac_l;
    logic [9:0] frac_s;
    logic [13:0] large_d;
    logic [13:0] small_d;
    logic [4:0] shamt_d;
    logic       op_sub_d;
    logic       a_nan, b_nan, a_inf, b_inf;
    logic       nan_d;
    logic       inf_d;

    // Order operands by magnitude and derive the alignment distance.
    always_comb begin
        eb_sign = io.b[15] ^ io.sub;
        a_large = (io.a[14:0] >= io.b[14:0]);
        sign_l  = io.a[15];
        sign_s  = eb_sign;
        exp_l   = io.a[14:10];
        exp_s   = io.b[14:10];
        frac_l  = io.a[9:0];
        frac_s  = io.b[9:0];
        if (!a_large) begin
            sign_l = eb_sign;
            sign_s = io.a[15];
            exp_l  = io.b[14:10];
            exp_s  = io.a[14:10];
            frac_l = io.b[9:0];
            frac_s = io.a[9:0];
        end
        large_d  = {(exp_l != 5'd0), frac_l, 3'b000};
        small_d  = {(exp_s != 5'd0), frac_s, 3'b000};
        // A denormal sits at effective exponent 1, so it is one step closer.
        shamt_d  = exp_l - exp_s - {4'b0000, (exp_l != 5'd0) && (exp_s == 5'd0)};
        op_sub_d = sign_l ^ sign_s;
        a_nan    = (io.a[14:10] == 5'h1f) && (io.a[9:0] != 10'd0);
        b_nan    = (io.b[14:10] == 5'h1f) && (io.b[9:0] != 10'd0);
        a_inf    = (io.a[14:10] == 5'h1f) && (io.a[9:0] == 10'd0);
        b_inf    = (io.b[14:10] == 5'h1f) && (io.b[9:0] == 10'd0);
        nan_d    = a_nan | b_nan | (a_inf & b_inf & op_sub_d);
        inf_d    = a_inf | b_inf;
    end

    logic        s1_sign_l;
    logic [4:0]  s1_exp_l;
    logic [13:0] s1_large;
    logic [13:0] s1_small;
    logic [4:0]  s1_shamt;
    logic        s1_op_sub;
    logic [1:0]  s1_rm;
    logic        s1_nan;
    logic        s1_inf;

    // Stage 1 register: advances whenever it is empty or stage 2 drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_sign_l <= 1'b0;
            s1_exp_l  <= 5'd0;
            s1_large  <= 14'd0;
            s1_small  <= 14'd0;
            s1_shamt  <= 5'd0;
            s1_op_sub <= 1'b0;
            s1_rm     <= 2'd0;
            s1_nan    <= 1'b0;
            s1_inf    <= 1'b0;
        end else if (s1_load) begin
            s1_valid  <= io.in_valid;
            s1_sign_l <= sign_l;
            s1_exp_l  <= exp_l;
            s1_large  <= large_d;
            s1_small  <= small_d;
            s1_shamt  <= shamt_d;
            s1_op_sub <= op_sub_d;
            s1_rm     <= io.rm_i;
            s1_nan    <= nan_d;
            s1_inf    <= inf_d;
        end
    end

    // ---------------- stage 2: align with sticky, add/sub, sign and specials
    logic [13:0] shifted;
    logic [13:0] sticky_mask;
    logic [13:0] aligned;
    logic [14:0] sum_d;
    logic        sign_d;
    logic [9:0]  inf_frac_d;

    // Align the small operand, fold shifted-out bits into the sticky position.
    always_comb begin
        shifted     = s1_small >> s1_shamt;
        sticky_mask = (14'd1 << s1_shamt) - 14'd1;
        if (s1_shamt >= 5'd14) begin
            aligned = {13'd0, |s1_small};
        end else begin
            aligned = {shifted[13:1], shifted[0] | (|(s1_small & sticky_mask))};
        end
        if (s1_op_sub) begin
            sum_d = {1'b0, s1_large} - {1'b0, aligned};
        end else begin
            sum_d = {1'b0, s1_large} + {1'b0, aligned};
        end
        // NaN results are emitted as the canonical positive quiet NaN.
        sign_d     = s1_sign_l;
        inf_frac_d = 10'd0;
        if (s1_nan) begin
            sign_d     = 1'b0;
            inf_frac_d = 10'h200;
        end else if (s1_inf) begin
            sign_d = s1_sign_l;
        end else if (s1_op_sub && (sum_d == 15'd0)) begin
            sign_d = (s1_rm == 2'b01);
        end
    end

    logic [14:0] cal_frac_q;
    logic [4:0]  temp_exp_q;
    logic        sign_q;
    logic        is_nan_q;
    logic        is_inf_q;
    logic [9:0]  inf_frac_q;
    logic [1:0]  rm_q;

    // Output register: holds steady while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            cal_frac_q  <= 15'd0;
            temp_exp_q  <= 5'd0;
            sign_q      <= 1'b0;
            is_nan_q    <= 1'b0;
            is_inf_q    <= 1'b0;
            inf_frac_q  <= 10'd0;
            rm_q        <= 2'd0;
        end else if (s2_load) begin
            out_valid_q <= s1_valid;
            cal_frac_q  <= sum_d;
            temp_exp_q  <= s1_exp_l;
            sign_q      <= sign_d;
            is_nan_q    <= s1_nan;
            is_inf_q    <= s1_inf & ~s1_nan;
            inf_frac_q  <= inf_frac_d;
            rm_q        <= s1_rm;
        end
    end

    assign io.out_valid    = out_valid_q;
    assign io.cal_frac     = cal_frac_q;
    assign io.temp_exp     = temp_exp_q;
    assign io.sign         = sign_q;
    assign io.is_nan       = is_nan_q;
    assign io.is_inf       = is_inf_q;
    assign io.inf_nan_frac = inf_frac_q;
    assign io.rm           = rm_q;

endmodule

// File: tb/tb_fadd_align_cal.sv
// Bench for fadd_align_cal: arithmetic reference model + scoreboard, directed vectors.
// Latency: checks 2-cycle unstalled latency and in-order delivery.
// Backpressure: exercises stall/freeze, in_ready drop, and mid-stream async reset.
module tb_fadd_align_cal;

    typedef struct packed {
        logic [14:0] cf;
        logic [4:0]  te;
        logic        s;
        logic        nan;
        logic        inf;
        logic [9:0]  ifr;
        logic [1:0]  rm;
    } res_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [1:0]  rm;
        logic        pin_num;
        logic [14:0] cf;
        logic [4:0]  te;
        logic        s;
        logic        nan;
        logic        inf;
        logic [9:0]  ifr;
    } vec_t;

    logic clk;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    res_t sb[$];
    vec_t tbl[17];
    res_t dut_res;

    fadd_align_cal_if bus ();

    fadd_align_cal dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dut_res = {bus.cal_frac, bus.temp_exp, bus.sign, bus.is_nan, bus.is_inf,
                      bus.inf_nan_frac, bus.rm};

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference: align on a wide integer using effective exponents, exact remainder as sticky.
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic sub, input logic [1:0] rm);
        res_t   r;
        logic   sa, sb_, sl;
        int     ea, eb, fa, fb, el, es, fl, fs, d;
        longint lx, sx, q, rem, al, sum;
        logic   esub, nan, inf;
        sa = a[15];
        sb_ = b[15] ^ sub;
        ea = int'(a[14:10]); fa = int'(a[9:0]);
        eb = int'(b[14:10]); fb = int'(b[9:0]);
        if (a[14:0] >= b[14:0]) begin
            sl = sa; el = ea; fl = fa; es = eb; fs = fb;
        end else begin
            sl = sb_; el = eb; fl = fb; es = ea; fs = fa;
        end
        lx = longint'(((el != 0) ? 1024 : 0) + fl) * 8;
        sx = longint'(((es != 0) ? 1024 : 0) + fs) * 8;
        d  = ((el == 0) ? 1 : el) - ((es == 0) ? 1 : es);
        q  = sx >> d;
        rem = sx - (q << d);
        al = q | ((rem != 0) ? 64'd1 : 64'd0);
        esub = sa ^ sb_;
        sum = esub ? (lx - al) : (lx + al);
        nan = (ea == 31 && fa != 0) || (eb == 31 && fb != 0) ||
              (ea == 31 && eb == 31 && fa == 0 && fb == 0 && esub);
        inf = !nan && (ea == 31 || eb == 31);
        r.cf  = sum[14:0];
        r.te  = el[4:0];
        r.nan = nan;
        r.inf = inf;
        r.ifr = nan ? 10'h200 : 10'h000;
        r.rm  = rm;
        if (nan)                   r.s = 1'b0;
        else if (inf)              r.s = (ea == 31) ? sa : sb_;
        else if (esub && sum == 0) r.s = (rm == 2'b01);
        else                       r.s = sl;
        return r;
    endfunction

    // Scoreboard: queue accepted operands, compare every valid output cycle.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 64'(bus.out_valid), 64'd0);
                end else begin
                    chk("result", 64'(dut_res), 64'(sb[0]));
                    if (bus.out_ready) void'(sb.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready)
                sb.push_back(model(bus.a, bus.b, bus.sub, bus.rm_i));
        end
    end

    task automatic send(input vec_t v);
        bus.in_valid = 1'b1;
        bus.a        = v.a;
        bus.b        = v.b;
        bus.sub      = v.sub;
        bus.rm_i     = v.rm;
        @(negedge clk);
        for (int k = 0; k < 50 && !bus.in_ready; k++) @(negedge clk);
        if (!bus.in_ready) chk("in_ready_timeout", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
        chk("drain", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            a        b        sub  rm     pin cf        te      s     nan   inf   ifr
        tbl[0]  = '{16'h3C00, 16'h3C00, 1'b0, 2'd0, 1'b1, 15'h4000, 5'd15, 1'b0, 1'b0, 1'b0, 10'h000};
        tbl[1]  = '{16'h4000, 16'h3C00, 1'b0, 2'd0, 1'b1, 15'h3000, 5'd16, 1'b0, 1'b0, 1'b0, 10'h000};
        tbl[2]  = '{16'h3C00, 16'h4000, 1'b0, 2'd0, 1'b1, 15'h3000, 5'd16, 1'b0, 1'b0, 1'b0, 10'h000};
        tbl[3]  = '{16'h3C00, 16'h3C00, 1'b1, 2'd0, 1'b1, 15'h0000, 5'd15, 1'b0, 1'b0, 1'b0, 10'h000};
        tbl[4]  = '{16'h3C00, 16'h3C00, 1'b1, 2'd1, 1'b1, 15'h0000, 5'd15, 1'b1, 1'b0, 1'b0, 10'h000};
        tbl[5]  = '{16'h3C00, 16'h0001, 1'b0, 2'd0, 1'b1, 15'h2001, 5'd15, 1'b0, 1'b0, 1'b0, 10'h000};
        tbl[6]  = '{16'h7C00, 16'h7C00, 1'b1, 2'd0, 1'b0, 15'h0000, 5'd0,  1'b0, 1'b1, 1'b0, 10'h200};
        tbl[7]  = '{16'h7C00, 16'h3C00, 1'b0, 2'd0, 1'b0, 15'h0000, 5'd0,  1'b0, 1'b0, 1'b1, 10'h000};
        tbl[8]  = '{16'hFC00, 16'h3C00, 1'b0, 2'd0, 1'b0, 15'h0000, 5'd0,  1'b1, 1'b0, 1'b1, 10'h000};
        tbl[9]  = '{16'h0003, 16'h0001, 1'b1, 2'd0, 1'b1, 15'h0010, 5'd0,  1'b0, 1'b0, 1'b0, 10'h000};
        tbl[10] = '{16'h0001, 16'h0001, 1'b1, 2'd2, 1'b1, 15'h0000, 5'd0,  1'b0, 1'b0, 1'b0, 10'h000};
        tbl[11] = '{16'h3C00, 16'h3BFF, 1'b1, 2'd0, 1'b1, 15'h0004, 5'd15, 1'b0, 1'b0, 1'b0, 10'h000};
        tbl[12] = '{16'hC000, 16'h3C00, 1'b0, 2'd0, 1'b1, 15'h1000, 5'd16, 1'b1, 1'b0, 1'b0, 10'h000};
        tbl[13] = '{16'h0400, 16'h0001, 1'b0, 2'd3, 1'b1, 15'h2008, 5'd1,  1'b0, 1'b0, 1'b0, 10'h000};
        tbl[14] = '{16'h7E00, 16'h3C00, 1'b0, 2'd0, 1'b0, 15'h0000, 5'd0,  1'b0, 1'b1, 1'b0, 10'h200};
        tbl[15] = '{16'h5BFF, 16'h0401, 1'b0, 2'd0, 1'b1, 15'h3FF9, 5'd22, 1'b0, 1'b0, 1'b0, 10'h000};
        tbl[16] = '{16'h0001, 16'h0001, 1'b1, 2'd1, 1'b1, 15'h0000, 5'd0,  1'b1, 1'b0, 1'b0, 10'h000};

        // Pin the reference model to hand-computed values.
        for (int i = 0; i < 17; i++) begin
            res_t r;
            r = model(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].rm);
            if (tbl[i].pin_num) begin
                chk($sformatf("pin_cf[%0d]", i), 64'(r.cf), 64'(tbl[i].cf));
                chk($sformatf("pin_te[%0d]", i), 64'(r.te), 64'(tbl[i].te));
            end
            chk($sformatf("pin_sign[%0d]", i), 64'(r.s), 64'(tbl[i].s));
            chk($sformatf("pin_spec[%0d]", i), 64'({r.nan, r.inf, r.ifr}),
                64'({tbl[i].nan, tbl[i].inf, tbl[i].ifr}));
        end

        // Reset state.
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = 16'd0;
        bus.b         = 16'd0;
        bus.sub       = 1'b0;
        bus.rm_i      = 2'd0;
        bus.out_ready = 1'b0;
        #2;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_data", 64'(dut_res), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;

        // Two-cycle latency on a lone transaction.
        bus.in_valid = 1'b1;
        bus.a = tbl[0].a; bus.b = tbl[0].b; bus.sub = tbl[0].sub; bus.rm_i = tbl[0].rm;
        @(negedge clk);
        chk("lat_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("lat_cycle1_out_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        chk("lat_cycle2_out_valid", 64'(bus.out_valid), 64'd1);
        chk("lat_cal_frac", 64'(bus.cal_frac), 64'h4000);
        chk("lat_temp_exp", 64'(bus.temp_exp), 64'd15);
        @(posedge clk);
        #1;
        drain();

        // Directed vectors back-to-back at full rate.
        for (int i = 0; i < 17; i++) send(tbl[i]);
        drain();

        // Backpressure: two accepted, third blocked, output frozen on the first.
        bus.out_ready = 1'b0;
        send(tbl[0]);
        send(tbl[1]);
        bus.in_valid = 1'b1;
        bus.a = tbl[12].a; bus.b = tbl[12].b; bus.sub = tbl[12].sub; bus.rm_i = tbl[12].rm;
        @(negedge clk);
        chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_frozen_cf", 64'(bus.cal_frac), 64'h4000);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_hold_in_ready", 64'(bus.in_ready), 64'd0);
            chk("bp_hold_cf", 64'(bus.cal_frac), 64'h4000);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        drain();

        // Mid-stream asynchronous reset discards in-flight data.
        bus.out_ready = 1'b0;
        send(tbl[3]);
        send(tbl[5]);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send(tbl[15]);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fadd_align_cal.md
Name: fadd_align_cal

Overview:
- Upstream stage of the fp16 adder. Feeds fadd_norm.
- Accepts two IEEE-754 half-precision operands plus an add/sub flag and rounding mode.
- Unpacks and swaps the operands, aligns the smaller one with guard/round/sticky, and performs the effective add or subtract.
- Two-stage elastic pipeline with valid/ready handshakes; outputs map one-to-one onto fadd_norm inputs.

Parameters:
- none (fp16 format fixed: 1 sign, 5 exp, 10 frac)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  operand set valid
- in_ready  out  1  stage can accept operand set
- a  in  16  operand A
- b  in  16  operand B
- sub  in  1  1 = A-B, 0 = A+B
- rm_i  in  2  rounding mode (00 nearest-even, 01 toward -inf, 10 toward +inf, 11 toward zero)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- cal_frac  out  15  [14] carry, [13] hidden, [12:3] fraction, [2:0] guard/round/sticky
- temp_exp  out  5  exponent field of larger-magnitude operand
- sign  out  1  result sign
- is_nan  out  1  result is NaN
- is_inf  out  1  result is infinity (not NaN)
- inf_nan_frac  out  10  fraction for special results
- rm  out  2  registered rm_i travelling with the data

Behaviour:
- Reset: out_valid=0, internal s1_valid=0, all data registers 0. Reset asserted mid-operation discards in-flight data.
- Handshake:
  - Transfer occurs on a cycle with valid&ready.
  - s2_load = ~out_valid | out_ready.
  - s1_load = ~s1_valid | s2_load.
  - in_ready = s1_load, combinational from state and out_ready.
  - While out_valid=1 and out_ready=0, all outputs hold stable.
  - Order is preserved; throughput is 1 per cycle.
  - Latency is 2 cycles from an accepted input to out_valid when unstalled.
- Stage 1 (registered on s1_load):
  - eb_sign = b[15]^sub.
  - Swap so that the large operand has {exp,frac}[14:0] >= the small operand's; on equality, A is large.
  - Hidden bit = (exp!=0).
  - shamt = exp_l - exp_s, minus 1 when exp_l!=0 and exp_s==0 (denormal small operand).
  - op_sub = sign_l ^ sign_s.
  - Register sign_l, exp_l, 14-bit large {hid,frac,3'b0}, small {hid,frac,3'b0}, shamt, op_sub, rm, and special flags.
- Stage 2 (registered on s2_load):
  - Shift the small operand right by shamt. Bit 0 = OR of the original bit 0 and all shifted-out bits (sticky).
  - shamt >= 14: aligned small = {13'b0, |small}.
  - cal_frac = {1'b0,large} ± {1'b0,aligned}; subtraction never underflows, by swap.
  - temp_exp = exp_l.
- Sign:
  - Normally sign_l.
  - If op_sub and cal_frac==0 (exact cancellation): sign = (rm==2'b01), and both specials stay 0.
- Specials (exp==31):
  - NaN if either operand is NaN (frac!=0), or both are inf with op_sub.
  - NaN result: is_nan=1, is_inf=0, inf_nan_frac=10'h200.
  - Otherwise inf if either operand is inf: is_inf=1, sign=sign of the inf operand (always the large one), inf_nan_frac=0.
  - Non-special: inf_nan_frac=0.
  - cal_frac/temp_exp still computed on special inputs (don't-care downstream).
- Sub-then-zero with both denormals: temp_exp=0, cal_frac is the raw difference.

Test Plan:
- 1.0+1.0 (a=3C00,b=3C00,sub=0,rm=00), out_ready=1 -> two cycles later out_valid=1, cal_frac=15'h4000, temp_exp=15, sign=0, is_nan=0, is_inf=0.
- 2.0+1.0 (a=4000,b=3C00) -> cal_frac=15'h3000, temp_exp=16, sign=0. Swapped order (a=3C00,b=4000) gives the same outputs.
- 1.0-1.0 (sub=1), rm=00 then rm=01 -> cal_frac=0, temp_exp=15, sign=0 then sign=1.
- 3C00+0001 (min denormal) -> shamt=14, cal_frac=15'h2001 (sticky set), temp_exp=15.
- 7C00-7C00 -> is_nan=1, inf_nan_frac=10'h200. 7C00+3C00 -> is_inf=1, sign=0, inf_nan_frac=0. FC00+3C00 -> is_inf=1, sign=1.
- Backpressure: send 3 back-to-back sets with out_ready=0 -> in_ready drops after 2 accepted, outputs frozen on the first. Raise out_ready -> results emerge in order, third accepted. rst pulsed mid-stream -> out_valid=0 asynchronously, nothing emitted afterwards.
